// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS polynomial taps, checker state encoding and saturating-increment helper shared by the PRBS blocks.
package prbs_pkg;
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    function automatic int tap_a(input int prbs_type);
        return prbs_type;
    endfunction

    // An illegal polynomial yields 0, which makes the tap index negative and fails elaboration.
    function automatic int tap_b(input int prbs_type);
        return prbs_type == 7  ? 6  :
               prbs_type == 9  ? 5  :
               prbs_type == 15 ? 14 :
               prbs_type == 23 ? 18 :
               prbs_type == 31 ? 28 : 0;
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] top;
        top = w >= 64 ? '1 : (64'(1) << w) - 64'(1);
        return v == top ? v : v + 64'(1);
    endfunction
endpackage

// File: rtl/prbs_rx_lfsr.sv
// prbs_rx_lfsr: checker shift register; loads received bits while hunting, free-runs its own prediction once locked.
module prbs_rx_lfsr
    import prbs_pkg::*;
#(
    parameter int PRBS_TYPE = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic din,
    input  logic inv,
    output logic exp,
    output logic nz
);
    localparam int TA = tap_a(PRBS_TYPE);
    localparam int TB = tap_b(PRBS_TYPE);

    logic [PRBS_TYPE-1:0] sr;

    assign exp = sr[TA-1] ^ sr[TB-1];
    assign nz  = |sr;

    // With an inverted stream sr holds inverted history, so the free-run bit is re-inverted to stay consistent.
    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else if (en)
            sr <= {sr[PRBS_TYPE-2:0], load ? din : exp ^ inv};
    end
endmodule

// File: rtl/prbs_rx.sv
// prbs_rx: self-synchronising PRBS checker with lock FSM, loss-of-sync window and saturating BER counters.
// Define PRBS_RX_AUTO_INV_EN to also lock on an inverted stream and report it on inv_det.
module prbs_rx
    import prbs_pkg::*;
#(
    parameter int PRBS_TYPE  = 7,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 128,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
`ifdef PRBS_RX_AUTO_INV_EN
    output logic             inv_det,
`endif
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int FW = $clog2(PRBS_TYPE + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(ERR_THRESH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PRBS_TYPE);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_MAX  = WW'(WIN_LEN - 1);
    localparam logic [EW:0]   THR      = (EW + 1)'(ERR_THRESH);

    logic [0:0]    state;
    logic [FW-1:0] fill;
    logic [MW-1:0] match, match_nx;
    logic [WW-1:0] win;
    logic [EW-1:0] werr;
    logic          exp, nz, hunt, full, lock_now, inv, e, drop, win_end, resync;

    prbs_rx_lfsr #(.PRBS_TYPE(PRBS_TYPE)) u_lfsr (
        .clk(clk), .rst(rst), .en(din_vld), .load(hunt), .din(din), .inv(inv), .exp(exp), .nz(nz)
    );

    assign hunt     = state == HUNT;
    assign locked   = state == LOCKED;
    assign full     = fill == FILL_MAX;
    assign match_nx = (full && nz && din == exp) ? match + MW'(1) : '0;
    assign e        = (din ^ inv) != exp;
    assign drop     = {1'b0, werr} + {{EW{1'b0}}, e} >= THR;
    assign win_end  = win == WIN_MAX;
    assign resync   = rst || (din_vld && !hunt && drop);

`ifdef PRBS_RX_AUTO_INV_EN
    logic [MW-1:0] match_i, match_i_nx;
    assign match_i_nx = (full && nz && din != exp) ? match_i + MW'(1) : '0;
    assign lock_now   = match_nx == LOCK_MAX || match_i_nx == LOCK_MAX;
    assign inv        = inv_det;
    always_ff @(posedge clk) begin
        if (resync) begin
            match_i <= '0;
            inv_det <= 1'b0;
        end else if (din_vld && hunt) begin
            match_i <= match_i_nx;
            inv_det <= match_i_nx == LOCK_MAX;
        end
    end
`else
    assign lock_now = match_nx == LOCK_MAX;
    assign inv      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resync) begin
            state <= HUNT;
            fill  <= '0;
            match <= '0;
            win   <= '0;
            werr  <= '0;
        end else if (din_vld && hunt) begin
            fill  <= full ? fill : fill + FW'(1);
            match <= match_nx;
            state <= lock_now ? LOCKED : HUNT;
        end else if (din_vld) begin
            win  <= win_end ? '0 : win + WW'(1);
            werr <= win_end ? '0 : werr + EW'(e);
        end
    end

    always_ff @(posedge clk) begin
        err <= rst ? 1'b0 : din_vld && !hunt && e;
        if (rst || clr_cnt) begin
            bit_cnt <= '0;
            err_cnt <= '0;
        end else if (din_vld && !hunt) begin
            bit_cnt <= CNT_W'(sat_inc(64'(bit_cnt), CNT_W));
            err_cnt <= e ? CNT_W'(sat_inc(64'(err_cnt), CNT_W)) : err_cnt;
        end
    end
endmodule

// File: tb/tb_prbs_rx.sv
// tb_prbs_rx: directed checks of prbs_rx on PRBS7 (lock, errors, loss of sync, gaps, clear, reset) and an inverted PRBS31 stream.
module tb_prbs_rx;
    logic        clk = 1'b0, rst = 1'b1;
    logic        din = 1'b0, din_vld = 1'b0, clr_cnt = 1'b0;
    logic        locked, err;
    logic [31:0] bit_cnt, err_cnt;
    logic        d31 = 1'b0, v31 = 1'b0;
    logic        locked31, err31;
    logic [31:0] bit31, err31_cnt;
`ifdef PRBS_RX_AUTO_INV_EN
    logic        inv_det, inv31;
`endif
    int          total = 0, bad = 0, errs = 0, lk = 0, lk31 = 0;
    logic [6:0]  s7  = 7'h4F;
    logic [30:0] s31 = 31'h1234567;

    always #5 clk = ~clk;

    prbs_rx #(.PRBS_TYPE(7)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked), .err(err),
`ifdef PRBS_RX_AUTO_INV_EN
        .inv_det(inv_det),
`endif
        .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    prbs_rx #(.PRBS_TYPE(31)) dut31 (
        .clk(clk), .rst(rst), .din(d31), .din_vld(v31), .clr_cnt(1'b0),
        .locked(locked31), .err(err31),
`ifdef PRBS_RX_AUTO_INV_EN
        .inv_det(inv31),
`endif
        .bit_cnt(bit31), .err_cnt(err31_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (err) errs++;
        if (locked) lk = 1;
        if (locked31) lk31 = 1;
    endtask

    // Transmitter model: next bit from the taps, shifted into the newest position.
    task automatic s7bit(input logic flip, input logic v);
        logic b;
        b       = s7[6] ^ s7[5];
        din_vld = v;
        din     = v ? b ^ flip : 1'($urandom);
        if (v) s7 = {s7[5:0], b};
        tick;
    endtask

    task automatic run7(input int n);
        repeat (n) s7bit(1'b0, 1'b1);
    endtask

    task automatic s31bit;
        logic b;
        b   = s31[30] ^ s31[27];
        d31 = ~b;
        v31 = 1'b1;
        s31 = {s31[29:0], b};
        tick;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_locked", 64'(locked), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_bit_cnt", 64'(bit_cnt), 0);
        chk("rst_err_cnt", 64'(err_cnt), 0);
        chk("rst_locked31", 64'(locked31), 0);
        rst = 1'b0;

        repeat (61) s31bit;
        chk("inv31_61", 64'(locked31), 0);
        repeat (2) s31bit;
`ifdef PRBS_RX_AUTO_INV_EN
        chk("inv31_lock", 64'(locked31), 1);
        chk("inv31_det", 64'(inv31), 1);
        repeat (200) s31bit;
        chk("inv31_bits", 64'(bit31), 200);
        chk("inv31_errs", 64'(err31_cnt), 0);
`else
        repeat (300) s31bit;
        chk("inv31_nolock", 64'(lk31), 0);
        chk("inv31_bits", 64'(bit31), 0);
`endif
        v31 = 1'b0;

        run7(38);
        chk("prelock38", 64'(locked), 0);
        run7(1);
        chk("lock39", 64'(locked), 1);
        chk("lock_bits", 64'(bit_cnt), 0);
        errs = 0;
        run7(1000);
        chk("clean_bits", 64'(bit_cnt), 1000);
        chk("clean_errcnt", 64'(err_cnt), 0);
        chk("clean_pulses", 64'(errs), 0);

        s7bit(1'b1, 1'b1);
        chk("err_pulse", 64'(err), 1);
        s7bit(1'b0, 1'b1);
        chk("err_once", 64'(err), 0);
        chk("err_cnt1", 64'(err_cnt), 1);
        chk("err_locked", 64'(locked), 1);

        clr_cnt = 1'b1;
        s7bit(1'b1, 1'b1);
        clr_cnt = 1'b0;
        chk("clr_err_cnt", 64'(err_cnt), 0);
        chk("clr_bit_cnt", 64'(bit_cnt), 0);

        run7(150);
        clr_cnt = 1'b1;
        s7bit(1'b0, 1'b0);
        clr_cnt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s7bit(1'b1, 1'b1);
            s7bit(1'b0, 1'b1);
        end
        chk("err7_locked", 64'(locked), 1);
        s7bit(1'b1, 1'b1);
        chk("drop_locked", 64'(locked), 0);
        chk("drop_err_cnt", 64'(err_cnt), 8);
        chk("drop_bit_cnt", 64'(bit_cnt), 15);
        run7(38);
        chk("relock38", 64'(locked), 0);
        run7(1);
        chk("relock39", 64'(locked), 1);
        chk("relock_err_cnt", 64'(err_cnt), 8);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 38; i++) begin
            s7bit(1'b0, 1'b1);
            s7bit(1'b0, 1'b0);
        end
        chk("gap_prelock", 64'(locked), 0);
        s7bit(1'b0, 1'b1);
        chk("gap_lock", 64'(locked), 1);
        for (int i = 0; i < 10; i++) begin
            s7bit(1'b0, 1'b0);
            s7bit(1'b0, 1'b1);
        end
        chk("gap_bits", 64'(bit_cnt), 10);
        chk("gap_errs", 64'(err_cnt), 0);

        s7bit(1'b1, 1'b1);
        chk("pre_rst_err_cnt", 64'(err_cnt), 1);
        rst = 1'b1;
        s7bit(1'b1, 1'b1);
        rst = 1'b0;
        chk("mid_rst_locked", 64'(locked), 0);
        chk("mid_rst_err", 64'(err), 0);
        chk("mid_rst_bits", 64'(bit_cnt), 0);
        chk("mid_rst_errs", 64'(err_cnt), 0);

        lk = 0;
        repeat (10000) begin
            din     = 1'b0;
            din_vld = 1'b1;
            tick;
        end
        chk("stuck0_lock", 64'(lk), 0);
        chk("stuck0_bits", 64'(bit_cnt), 0);
        repeat (10000) begin
            din     = 1'($urandom);
            din_vld = 1'b1;
            tick;
        end
        chk("random_lock", 64'(lk), 0);
        chk("random_bits", 64'(bit_cnt), 0);
        chk("random_errs", 64'(err_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
